seidel_mul_arbiter: RTL and testbench
=====================================

# seidel_mul_arbiter

Round-robin arbiter that shares one pipelined unsigned multiplier (10x11 operands, 20-bit product, 3-cycle latency, clock-enable driven) between N_REQ requesters in the seidel-2d kernel datapath. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle. It tracks each in-flight product with a tag pipeline that matches the multiplier latency, and steers each result back to its originating requester. It also drives the multiplier's `ce`, so it is the sole sequencer of that resource.

## Interface
- N_REQ, 2: number of requesters (2..4)
- A_W, 10: operand A width
- B_W, 11: operand B width
- P_W, 20: product width (low P_W bits of A*B)
- LAT, 3: multiplier latency in ce-enabled clock edges

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester grant, one-hot or zero
- req_a  in  N_REQ*A_W  packed operand A, requester i at [i*A_W +: A_W]
- req_b  in  N_REQ*B_W  packed operand B
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  A_W  operand A to multiplier
- mul_din1  out  B_W  operand B to multiplier
- mul_dout  in  P_W  product from multiplier
- rsp_valid  out  N_REQ  one-hot result strobe, one cycle
- rsp_p  out  P_W  result, equals mul_dout
- busy  out  1  any tag stage occupied

## Operation
- Arbitration: rotating pointer `last` (last granted index). Winner = first i with req_valid[i] set, searching from last+1 modulo N_REQ. req_ready[winner] = 1 combinationally, all other bits 0. Handshake completes on the edge where valid & ready are both high. On completion, `last` is set to winner.
- Requesters hold req_valid and operands stable until ready. Dropping valid before the grant is legal.
- mul_din0/1 = winner's operands when a grant occurs, otherwise 0.
- Tag pipeline: LAT stages of {v, idx[clog2(N_REQ)]}. Stage 0 loads {grant, winner} and stages shift on every edge where mul_ce=1. The response is taken from stage LAT-1: rsp_valid[idx] = v.
- No response backpressure. Requesters must accept rsp_valid in the cycle it is asserted.
- Width: the multiplier truncates the product. rsp_p = (A*B) mod 2^P_W, passed through unmodified.
- Reset (asynchronous, active-low): all tag v bits = 0, last = N_REQ-1 (requester 0 wins first), rsp_valid=0, req_ready=0, busy=0, mul_ce=0. The multiplier's internal registers are not reset, so stale data may emerge, but no rsp_valid is raised for it.
- Reset during operation: in-flight products are dropped silently, with no response after release.

## Timing
- Grant on edge t, so the result is at rsp_p/rsp_valid during cycle t+LAT (with ce held high).
- Throughput is 1 grant per cycle. Back-to-back grants yield back-to-back responses in grant order.
- A grant and a response in the same cycle are independent and both occur.
- Worst-case wait with all requesters continuously valid: N_REQ-1 cycles.

## Configuration
- SEIDEL_MUL_ARB_CE_GATE_EN defined: mul_ce = grant | (any tag v). The multiplier is frozen when idle. The tag pipeline only advances with ce, so in-flight results are preserved when ce is low.
- Not defined: mul_ce = 1 whenever reset is deasserted, and the tag pipeline shifts every cycle. Latency is identical.

## Test plan
- Single request: req0 a=1023, b=2047, granted at edge t. Required: rsp_valid=0b01 and rsp_p=1045505 (0xFF401, truncated from 2094081) in cycle t+3, and nothing else.
- Contention: req0 and req1 both held valid for 6 cycles with distinct operands. Required: grants 0,1,0,1,0,1 (0 first after reset), and responses in the same order 3 cycles later, one per cycle.
- Hold/drop: req1 valid with a=5, b=7 while req0 takes a grant. Required: req1 is granted on the next cycle, and rsp_p=35 with rsp_valid=0b10 three cycles after that.
- Reset mid-flight: two grants issued, then reset pulsed low one cycle later. Required: rsp_valid stays 0 through and after reset, busy=0, and the next simultaneous request goes to requester 0.
- CE gating (macro defined): one grant, then idle. Required: mul_ce high on the grant cycle and the following 2 cycles, then 0. Busy drops with the last response.
- CE gating off: mul_ce=1 every cycle after reset release, and the single-request latency is unchanged.

Source files
------------

// File: rtl/seidel_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between N_REQ requesters.
// Define SEIDEL_MUL_ARB_CE_GATE_EN to freeze the multiplier (mul_ce low) when idle.
module seidel_mul_arbiter #(
  parameter int N_REQ = 2,
  parameter int A_W   = 10,
  parameter int B_W   = 11,
  parameter int P_W   = 20,
  parameter int LAT   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic                   mul_ce,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] winner, cand;
  logic             found, grant, in_flight;
  logic [LAT-1:0]   v_q, v_d;
  logic [IDX_W-1:0] idx_q [LAT];
  logic [IDX_W-1:0] idx_d [LAT];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant     = found & reset;
  assign last_d    = grant ? winner : last_q;
  assign in_flight = |v_q[LAT-2:0];
  assign busy      = |v_q;
  assign rsp_p     = mul_dout;

`ifdef SEIDEL_MUL_ARB_CE_GATE_EN
  assign mul_ce = grant | in_flight;
`else
  assign mul_ce = reset;
`endif

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && winner == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[i*A_W +: A_W];
        mul_din1     = req_b[i*B_W +: B_W];
      end
      if (v_q[LAT-1] && idx_q[LAT-1] == IDX_W'(i)) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  // The last stage only marks a product already on rsp_p, so it empties when ce stops.
  always_comb begin
    v_d   = v_q;
    idx_d = idx_q;
    if (mul_ce) begin
      v_d      = {v_q[LAT-2:0], grant};
      idx_d[0] = winner;
      for (int i = 1; i < LAT; i++) begin
        idx_d[i] = idx_q[i-1];
      end
    end else begin
      v_d[LAT-1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= IDX_W'(N_REQ - 1);
      v_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      last_q <= last_d;
      v_q    <= v_d;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= idx_d[i];
      end
    end
  end

endmodule

// File: tb/tb_seidel_mul_arbiter.sv
// Self-checking bench for seidel_mul_arbiter: a reference arbiter model feeds a
// response scoreboard, while scenario tasks check timing-specific behaviour inline.
module tb_seidel_mul_arbiter;
   localparam int N_REQ = 2;
   localparam int A_W   = 10;
   localparam int B_W   = 11;
   localparam int P_W   = 20;
   localparam int LAT   = 3;
`ifdef SEIDEL_MUL_ARB_CE_GATE_EN
   localparam bit CE_GATE = 1'b1;
`else
   localparam bit CE_GATE = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ*A_W-1:0] req_a;
   logic [N_REQ*B_W-1:0] req_b;
   logic                 mul_ce;
   logic [A_W-1:0]       mul_din0;
   logic [B_W-1:0]       mul_din1;
   logic [P_W-1:0]       mul_dout;
   logic [N_REQ-1:0]     rsp_valid;
   logic [P_W-1:0]       rsp_p;
   logic                 busy;

   logic                 drvV [N_REQ];
   logic [A_W-1:0]       drvA [N_REQ];
   logic [B_W-1:0]       drvB [N_REQ];

   int nCmp = 0;
   int nFail = 0;
   int cyc = 0;

   seidel_mul_arbiter #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
      .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Requester drive arrays are packed onto the DUT buses.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_valid[i]           = drvV[i];
         req_a[i*A_W +: A_W]    = drvA[i];
         req_b[i*B_W +: B_W]    = drvB[i];
      end
   end

   // Behavioural multiplier: LAT ce-enabled stages, product truncated to P_W bits.
   logic [P_W-1:0] mPipe [LAT];
   always @(posedge clk) begin
      if (mul_ce) begin
         mPipe[0] <= P_W'(32'(mul_din0) * 32'(mul_din1));
         for (int i = 1; i < LAT; i++) mPipe[i] <= mPipe[i-1];
      end
   end
   assign mul_dout = mPipe[LAT-1];

   typedef struct {
      logic [N_REQ-1:0] oh;
      logic [P_W-1:0]   p;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   lastM = N_REQ - 1;
   int   win;
   int   cand;
   logic [N_REQ-1:0] expReady;

   // Reference arbiter and response scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         lastM = N_REQ - 1;
      end else begin
         if (rsp_valid !== '0) begin
            nCmp++;
            if (sb.size() == 0) begin
               nFail++;
               $display("[TB] FAIL rsp_unexpected: cycle %0d got valid=%b p=%0d, required no response", cyc, rsp_valid, rsp_p);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== e.oh || rsp_p !== e.p || cyc != e.cyc) begin
                  nFail++;
                  $display("[TB] FAIL rsp_match: got valid=%b p=%0d cycle %0d, required valid=%b p=%0d cycle %0d",
                           rsp_valid, rsp_p, cyc, e.oh, e.p, e.cyc);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            nCmp++;
            nFail++;
            $display("[TB] FAIL rsp_missing: got none by cycle %0d, required valid=%b p=%0d at cycle %0d",
                     cyc, sb[0].oh, sb[0].p, sb[0].cyc);
            void'(sb.pop_front());
         end

         win = -1;
         for (int k = 1; k <= N_REQ; k++) begin
            cand = (lastM + k) % N_REQ;
            if (win < 0 && drvV[cand]) win = cand;
         end
         expReady = '0;
         if (win >= 0) expReady[win] = 1'b1;
         nCmp++;
         if (req_ready !== expReady) begin
            nFail++;
            $display("[TB] FAIL ready_model: cycle %0d got %b, required %b", cyc, req_ready, expReady);
         end
         if (win >= 0) begin
            nCmp++;
            if (mul_din0 !== drvA[win] || mul_din1 !== drvB[win]) begin
               nFail++;
               $display("[TB] FAIL operands: got a=%0d b=%0d, required a=%0d b=%0d",
                        mul_din0, mul_din1, drvA[win], drvB[win]);
            end
            sb.push_back('{oh: expReady, p: P_W'(32'(drvA[win]) * 32'(drvB[win])), cyc: cyc + LAT});
            lastM = win;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic waitSample();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      for (int i = 0; i < N_REQ; i++) begin
         drvV[i] = 1'b0;
         drvA[i] = '0;
         drvB[i] = '0;
      end
   endtask

   task automatic doReset();
      waitDrive();
      reset = 1'b0;
      waitDrive();
      waitDrive();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N_REQ; i++) begin
         drvV[i] = 1'b1;
         drvA[i] = A_W'(i + 1);
         drvB[i] = B_W'(i + 2);
      end
      reset = 1'b0;
      waitSample();
      nCmp++;
      if (req_ready !== '0) begin nFail++; $display("[TB] FAIL reset_ready: got %b, required 0", req_ready); end
      nCmp++;
      if (rsp_valid !== '0) begin nFail++; $display("[TB] FAIL reset_rsp: got %b, required 0", rsp_valid); end
      nCmp++;
      if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
      nCmp++;
      if (mul_ce !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ce: got %b, required 0", mul_ce); end
      waitDrive();
      clearInputs();
      reset = 1'b1;
      waitSample();
      nCmp++;
      if (mul_ce !== !CE_GATE) begin nFail++; $display("[TB] FAIL idle_ce: got %b, required %b", mul_ce, !CE_GATE); end
      nCmp++;
      if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL idle_busy: got %b, required 0", busy); end
   endtask

   task automatic test_single();
      logic [N_REQ-1:0] expRsp;
      waitDrive();
      drvV[0] = 1'b1;
      drvA[0] = 10'd1023;
      drvB[0] = 11'd2047;
      waitSample();
      nCmp++;
      if (req_ready !== 2'b01) begin nFail++; $display("[TB] FAIL single_ready: got %b, required 01", req_ready); end
      nCmp++;
      if (mul_ce !== 1'b1) begin nFail++; $display("[TB] FAIL single_ce_grant: got %b, required 1", mul_ce); end
      waitDrive();
      drvV[0] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         waitSample();
         expRsp = (k == 3) ? 2'b01 : 2'b00;
         nCmp++;
         if (rsp_valid !== expRsp) begin nFail++; $display("[TB] FAIL single_rsp_t%0d: got %b, required %b", k, rsp_valid, expRsp); end
         if (k == 3) begin
            nCmp++;
            if (rsp_p !== 20'd1045505) begin nFail++; $display("[TB] FAIL single_p: got %0d, required 1045505", rsp_p); end
         end
         nCmp++;
         if (mul_ce !== (!CE_GATE || k <= 2)) begin
            nFail++;
            $display("[TB] FAIL single_ce_t%0d: got %b, required %b", k, mul_ce, (!CE_GATE || k <= 2));
         end
         nCmp++;
         if (busy !== (k <= 3)) begin nFail++; $display("[TB] FAIL single_busy_t%0d: got %b, required %b", k, busy, (k <= 3)); end
      end
   endtask

   task automatic test_contention();
      logic [N_REQ-1:0] expReq;
      int g;
      doReset();
      drvA[0] = 10'd100; drvB[0] = 11'd200;
      drvA[1] = 10'd300; drvB[1] = 11'd400;
      drvV[0] = 1'b1;
      drvV[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         waitSample();
         g = k % 2;
         expReq = (g == 0) ? 2'b01 : 2'b10;
         nCmp++;
         if (req_ready !== expReq) begin nFail++; $display("[TB] FAIL contend_grant%0d: got %b, required %b", k, req_ready, expReq); end
         waitDrive();
         drvA[g] = drvA[g] + 10'd7;
         drvB[g] = drvB[g] + 11'd13;
      end
      clearInputs();
      repeat (LAT + 2) waitSample();
   endtask

   task automatic test_hold_drop();
      waitDrive();
      drvV[0] = 1'b1; drvA[0] = 10'd3; drvB[0] = 11'd4;
      drvV[1] = 1'b1; drvA[1] = 10'd5; drvB[1] = 11'd7;
      waitSample();
      nCmp++;
      if (req_ready !== 2'b01) begin nFail++; $display("[TB] FAIL hold_first: got %b, required 01", req_ready); end
      waitDrive();
      drvV[0] = 1'b0;
      waitSample();
      nCmp++;
      if (req_ready !== 2'b10) begin nFail++; $display("[TB] FAIL hold_second: got %b, required 10", req_ready); end
      waitDrive();
      drvV[1] = 1'b0;
      waitSample();
      waitSample();
      nCmp++;
      if (rsp_valid !== 2'b01 || rsp_p !== 20'd12) begin
         nFail++; $display("[TB] FAIL hold_rsp0: got %b/%0d, required 01/12", rsp_valid, rsp_p);
      end
      waitSample();
      nCmp++;
      if (rsp_valid !== 2'b10 || rsp_p !== 20'd35) begin
         nFail++; $display("[TB] FAIL hold_rsp1: got %b/%0d, required 10/35", rsp_valid, rsp_p);
      end
      repeat (2) waitSample();
   endtask

   task automatic test_reset_midflight();
      waitDrive();
      drvV[0] = 1'b1; drvA[0] = 10'd11; drvB[0] = 11'd13;
      waitDrive();
      drvV[0] = 1'b0;
      drvV[1] = 1'b1; drvA[1] = 10'd17; drvB[1] = 11'd19;
      waitDrive();
      drvV[1] = 1'b0;
      reset = 1'b0;
      waitSample();
      nCmp++;
      if (busy !== 1'b0 || rsp_valid !== '0) begin
         nFail++; $display("[TB] FAIL midreset_during: got busy=%b rsp=%b, required 0/00", busy, rsp_valid);
      end
      waitDrive();
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         waitSample();
         nCmp++;
         if (busy !== 1'b0 || rsp_valid !== '0) begin
            nFail++; $display("[TB] FAIL midreset_after%0d: got busy=%b rsp=%b, required 0/00", k, busy, rsp_valid);
         end
      end
      waitDrive();
      drvV[0] = 1'b1; drvA[0] = 10'd21; drvB[0] = 11'd22;
      drvV[1] = 1'b1; drvA[1] = 10'd23; drvB[1] = 11'd24;
      waitSample();
      nCmp++;
      if (req_ready !== 2'b01) begin nFail++; $display("[TB] FAIL midreset_first: got %b, required 01", req_ready); end
      waitDrive();
      clearInputs();
      repeat (LAT + 2) waitSample();
   endtask

   initial begin
      clearInputs();
      test_reset();
      test_single();
      test_contention();
      test_hold_drop();
      test_reset_midflight();
      repeat (4) waitSample();
      nCmp++;
      if (sb.size() != 0) begin nFail++; $display("[TB] FAIL sb_drain: got %0d pending, required 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
